// File: rtl/dm_store_buffer_if.sv
// Bus bundle for the data-memory store buffer: request side, memory drain port and load-hazard query.
// The master modport is the pipeline/memory side that drives the buffer, and the slave modport is the buffer itself.
interface dm_store_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int LANES = DATA_W / 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              st_ades;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_byteen;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [CW-1:0]     count;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_ready, ld_addr,
    input  req_ready, st_ades, mem_valid, mem_addr, mem_wdata, mem_byteen, ld_hit, count
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_ready, ld_addr,
    output req_ready, st_ades, mem_valid, mem_addr, mem_wdata, mem_byteen, ld_hit, count
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Store path for the data-memory stage: sb/sh/sw decode, alignment check, and an in-order store FIFO
// draining to memory, with a same-word hazard flag for the load path.
module dm_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_store_buffer_if.slave     bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_SB   = 2'd1;
  localparam logic [1:0] OP_SH   = 2'd2;
  localparam logic [1:0] OP_SW   = 2'd3;

  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      OP_SH:   return lo[0];
      OP_SW:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] enc_be(input logic [1:0] op, input logic [LB-1:0] off);
    case (op)
      OP_SB:   return LANES'(1) << off;
      OP_SH:   return LANES'(3) << off;
      OP_SW:   return LANES'(15) << off;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] enc_data(input logic [1:0] op, input logic [31:0] w);
    case (op)
      OP_SB:   return {LANES{w[7:0]}};
      OP_SH:   return {(LANES/2){w[15:0]}};
      default: return {(LANES/4){w}};
    endcase
  endfunction

  // ---- p0: request decode and encode ----
  logic              misal_p0;
  logic              push_p0;
  logic [LANES-1:0]  be_p0;
  logic [DATA_W-1:0] data_p0;
  logic [ADDR_W-1:0] word_p0;

  assign misal_p0 = misaligned(bus.req_op, bus.req_addr[1:0]);
  assign be_p0    = enc_be(bus.req_op, bus.req_addr[LB-1:0]);
  assign data_p0  = enc_data(bus.req_op, bus.req_wdata);
  assign word_p0  = {bus.req_addr[ADDR_W-1:LB], {LB{1'b0}}};

  // ---- p1: queued entries ----
  logic [ADDR_W-1:0] addr_p1 [DEPTH];
  logic [DATA_W-1:0] data_p1 [DEPTH];
  logic [LANES-1:0]  be_p1   [DEPTH];
  logic [DEPTH-1:0]  vld_p1;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              empty;
  logic              pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Full refuses a push even when the head drains in the same cycle, keeping the ready path pop-independent.
  assign push_p0 = bus.req_valid && !full && (bus.req_op != OP_NONE) && !misal_p0;
  assign pop     = !empty && bus.mem_ready;

  assign bus.req_ready = !full;
  assign bus.st_ades   = bus.req_valid && misal_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld_p1 <= '0;
    end else begin
      if (push_p0) begin
        wr_ptr         <= wr_ptr + PW'(1);
        vld_p1[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        vld_p1[rd_ptr] <= 1'b0;
      end
      case ({push_p0, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: it is only visible through valid bits and the empty gating below.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      addr_p1[wr_ptr] <= word_p0;
      data_p1[wr_ptr] <= data_p0;
      be_p1[wr_ptr]   <= be_p0;
    end
  end

  assign bus.mem_valid  = !empty;
  assign bus.mem_addr   = empty ? '0 : addr_p1[rd_ptr];
  assign bus.mem_wdata  = empty ? '0 : data_p1[rd_ptr];
  assign bus.mem_byteen = empty ? '0 : be_p1[rd_ptr];
  assign bus.count      = cnt;

  // A store pushed this cycle is not yet in vld_p1, so it only becomes visible to loads next cycle.
  always_comb begin
    bus.ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_p1[i] && ((addr_p1[i] >> LB) == (bus.ld_addr >> LB)))
        bus.ld_hit = 1'b1;
    end
  end
endmodule
